// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: opcodes, FSM encoding,
// memory geometry and the HALT instruction word shown while loading.
package instr_fetch_pkg;

    // Opcode field values (instr[31:26])
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Instruction memory geometry
    localparam int MEM_WORDS = 64;
    localparam int ADDR_W    = 6;

    // Word presented while loading so downstream control writes nothing
    localparam logic [31:0] HALT_WORD = {OP_HALT, 26'd0};

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Next sequential or branch PC, 32-bit modulo
    function automatic logic [31:0] next_pc(
        input logic [31:0] cur_pc,
        input logic        take_branch,
        input logic [31:0] offset
    );
        logic [31:0] seq;
        seq = cur_pc + 32'd4;
        if (take_branch) begin
            return seq + (offset << 2);
        end
        return seq;
    endfunction

endpackage

// File: rtl/instr_rom.sv
// 64 x 32 instruction memory: synchronous write port for program loading,
// asynchronous read port addressed by the word index of the PC.
module instr_rom
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:MEM_WORDS-1];

    // Program write; contents are deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: program-load / run / halt state machine, program
// counter, and instruction field decode on top of instr_rom.
//
// Load handshake: load_ready is high only in LOAD; a word is written on each
// rising edge where load_ready and load_valid are both high. load_valid is
// ignored outside LOAD, and a write coinciding with Reset is dropped.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic         CLK,
    input  logic         Reset,
    input  logic         PCWre,
    input  logic         PCSrc,
    input  logic [31:0]  imm_ext,
    input  logic         run,
    input  logic         load_valid,
    input  logic [5:0]   load_addr,
    input  logic [31:0]  load_data,
    output logic         load_ready,
    output logic [31:0]  pc,
    output logic [31:0]  instr,
    output logic [5:0]   op,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   rd,
    output logic [15:0]  imm16,
    output logic         instr_valid,
    output logic         halted,
    output fetch_state_t fsm_state
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  rom_data;
    logic         mem_we;

    // Writes only land in LOAD and never when reset wins the edge
    assign mem_we = (state == ST_LOAD) && load_valid && !Reset;

    instr_rom u_rom (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q[7:2]),
        .rdata (rom_data)
    );

    // State machine, PC and registered status flags
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= ST_LOAD;
            pc_q        <= 32'd0;
            load_ready  <= 1'b1;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    // A pending write keeps us loading even if run is high
                    if (run && !load_valid) begin
                        state       <= ST_RUN;
                        load_ready  <= 1'b0;
                        instr_valid <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (PCWre) begin
                        pc_q <= next_pc(pc_q, PCSrc, imm_ext);
                    end else begin
                        state       <= ST_HALT;
                        load_ready  <= 1'b0;
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // Only reset leaves HALT
                end
                default: begin
                    state       <= ST_LOAD;
                    pc_q        <= 32'd0;
                    load_ready  <= 1'b1;
                    instr_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

    // While loading, present HALT so nothing downstream commits
    always_comb begin
        instr = rom_data;
        if (state == ST_LOAD) begin
            instr = HALT_WORD;
        end
    end

    assign pc        = pc_q;
    assign op        = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign imm16     = instr[15:0];
    assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each step drives one clock edge and queues
// the hand-computed state expected after that edge; a negedge monitor pops
// and compares against the DUT outputs.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         Reset = 1'b1;
    logic         PCWre = 1'b0;
    logic         PCSrc = 1'b0;
    logic [31:0]  imm_ext = 32'd0;
    logic         run = 1'b0;
    logic         load_valid = 1'b0;
    logic [5:0]   load_addr = 6'd0;
    logic [31:0]  load_data = 32'd0;
    logic         load_ready;
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [5:0]   op;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [15:0]  imm16;
    logic         instr_valid;
    logic         halted;
    fetch_state_t fsm_state;

    instr_fetch dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PCWre       (PCWre),
        .PCSrc       (PCSrc),
        .imm_ext     (imm_ext),
        .run         (run),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .pc          (pc),
        .instr       (instr),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  st;     // 0 LOAD, 1 RUN, 2 HALT
    } exp_t;

    exp_t   exp_q[$];
    string  name_q[$];
    int     vectors = 0;
    int     miscompares = 0;

    // Compare DUT outputs against the oldest queued expectation
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic        e_lr;
            logic        e_iv;
            logic        e_h;
            fetch_state_t e_fsm;
            logic        ok;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            e_lr  = (e.st == 2'd0);
            e_iv  = (e.st == 2'd1);
            e_h   = (e.st == 2'd2);
            e_fsm = (e.st == 2'd0) ? ST_LOAD : (e.st == 2'd1) ? ST_RUN : ST_HALT;
            ok = (pc === e.pc) && (instr === e.instr) &&
                 (op === e.instr[31:26]) && (rs === e.instr[25:21]) &&
                 (rt === e.instr[20:16]) && (rd === e.instr[15:11]) &&
                 (imm16 === e.instr[15:0]) && (load_ready === e_lr) &&
                 (instr_valid === e_iv) && (halted === e_h) &&
                 (fsm_state === e_fsm);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s: got pc=%h instr=%h op=%b lr=%b iv=%b h=%b st=%0d, want pc=%h instr=%h lr=%b iv=%b h=%b st=%0d",
                         nm, pc, instr, op, load_ready, instr_valid, halted, fsm_state,
                         e.pc, e.instr, e_lr, e_iv, e_h, e_fsm);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(
        input string       nm,
        input logic        rst,
        input logic        wre,
        input logic        src,
        input logic [31:0] imm,
        input logic        rn,
        input logic        lv,
        input logic [5:0]  la,
        input logic [31:0] ld,
        input logic [31:0] e_pc,
        input logic [31:0] e_instr,
        input logic [1:0]  e_st
    );
        exp_t e;
        Reset      = rst;
        PCWre      = wre;
        PCSrc      = src;
        imm_ext    = imm;
        run        = rn;
        load_valid = lv;
        load_addr  = la;
        load_data  = ld;
        @(posedge CLK);
        #1;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.st    = e_st;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    localparam logic [31:0] W0  = 32'h0000_0000;
    localparam logic [31:0] W1  = 32'h4400_0000;
    localparam logic [31:0] W2  = 32'hFC00_0000;
    localparam logic [31:0] W3  = 32'h28A3_0005;
    localparam logic [31:0] W63 = 32'h0109_502A;
    localparam logic [31:0] HW  = 32'hFC00_0000;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        //    name            rst we src imm           run lv addr   data          pc            instr st
        step("reset",          1, 0, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h0,        HW,  2'd0);
        step("load0",          0, 0, 0, 32'h0,        0, 1, 6'd0,  W0,           32'h0,        HW,  2'd0);
        step("load1",          0, 0, 0, 32'h0,        0, 1, 6'd1,  W1,           32'h0,        HW,  2'd0);
        step("load2",          0, 0, 0, 32'h0,        0, 1, 6'd2,  W2,           32'h0,        HW,  2'd0);
        step("load3",          0, 0, 0, 32'h0,        0, 1, 6'd3,  W3,           32'h0,        HW,  2'd0);
        step("load63_run",     0, 0, 0, 32'h0,        1, 1, 6'd63, W63,          32'h0,        HW,  2'd0);
        step("rst_drop_wr",    1, 0, 0, 32'h0,        0, 1, 6'd1,  32'hDEADBEEF, 32'h0,        HW,  2'd0);
        step("run_enter",      0, 1, 0, 32'h0,        1, 0, 6'd0,  32'h0,        32'h0,        W0,  2'd1);
        step("seq_pc4",        0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h4,        W1,  2'd1);
        step("seq_pc8",        0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h8,        W2,  2'd1);
        step("br_back0",       0, 1, 1, 32'hFFFFFFFD, 0, 0, 6'd0,  32'h0,        32'h0,        W0,  2'd1);
        step("seq_pc4b",       0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h4,        W1,  2'd1);
        step("seq_pc8b",       0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h8,        W2,  2'd1);
        step("seq_pc12",       0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'hC,        W3,  2'd1);
        step("rst_mid_run",    1, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h0,        HW,  2'd0);
        step("rerun",          0, 1, 0, 32'h0,        1, 0, 6'd0,  32'h0,        32'h0,        W0,  2'd1);
        step("br_alias100",    0, 1, 1, 32'h0000003F, 0, 0, 6'd0,  32'h0,        32'h100,      W0,  2'd1);
        step("alias104",       0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h104,      W1,  2'd1);
        step("br_top",         0, 1, 1, 32'hFFFFFFBD, 0, 0, 6'd0,  32'h0,        32'hFFFFFFFC, W63, 2'd1);
        step("wrap0",          0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h0,        W0,  2'd1);
        step("seq_pc4c",       0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h4,        W1,  2'd1);
        step("halt_enter",     0, 0, 1, 32'h00000010, 0, 0, 6'd0,  32'h0,        32'h4,        W1,  2'd2);
        step("halt_ign_ld",    0, 0, 0, 32'h0,        1, 1, 6'd1,  32'hDEADBEEF, 32'h4,        W1,  2'd2);
        step("halt_ign_pc",    0, 1, 1, 32'h00000004, 1, 0, 6'd0,  32'h0,        32'h4,        W1,  2'd2);
        step("rst_in_halt",    1, 0, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h0,        HW,  2'd0);
        step("rerun2",         0, 1, 0, 32'h0,        1, 0, 6'd0,  32'h0,        32'h0,        W0,  2'd1);
        step("mem1_intact",    0, 1, 0, 32'h0,        0, 0, 6'd0,  32'h0,        32'h4,        W1,  2'd1);

        // Let the monitor drain the queue
        PCWre = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
